// File: rtl/sram_like_multi_bridge_if.sv
// Sram-like master bus for NCH independent channels: request side driven by the
// bridge (master), handshake and read data returned by the memory side (slave).
interface sram_like_multi_bridge_if #(
  parameter int NCH = 2,
  parameter int AW  = 32
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    wr;
  logic [2*NCH-1:0]  size;
  logic [AW*NCH-1:0] addr;
  logic [32*NCH-1:0] wdata;
  logic [NCH-1:0]    addr_ok;
  logic [NCH-1:0]    data_ok;
  logic [32*NCH-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_multi_bridge.sv
// Bridge from the core's enable/stall memory ports to NCH sram-like master channels.
// Define SRAM_BRIDGE_PERF_EN to add per-channel stall-cycle and request counters.
module sram_like_multi_bridge #(
  parameter int NCH = 2,
  parameter int AW  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NCH-1:0]           cpu_en,
  input  logic [4*NCH-1:0]         cpu_wen,
  input  logic [AW*NCH-1:0]        cpu_addr,
  input  logic [32*NCH-1:0]        cpu_wdata,
  output logic [32*NCH-1:0]        cpu_rdata,
  output logic [NCH-1:0]           cpu_stall,
  output logic                     longest_stall,
  sram_like_multi_bridge_if.master bus
`ifdef SRAM_BRIDGE_PERF_EN
  ,
  output logic [32*NCH-1:0]        perf_stall_cnt,
  output logic [32*NCH-1:0]        perf_req_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [NCH-1:0]    req_c;
  logic [NCH-1:0]    capture;
  logic [NCH-1:0]    rdata_ld;
  logic [NCH-1:0]    wr_q;
  logic [2*NCH-1:0]  size_q;
  logic [AW*NCH-1:0] addr_q;
  logic [32*NCH-1:0] wdata_q;
  logic [32*NCH-1:0] rdata_q;

  // Illegal byte-enable patterns fall through to a word access.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_to_size = 2'd0;
      4'b0011, 4'b1100:                   wen_to_size = 2'd1;
      default:                            wen_to_size = 2'd2;
    endcase
  endfunction

  // A held channel no longer stalls, so the early finisher waits silently for the rest.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cpu_stall[i] = cpu_en[i] && (state_q[i] != HOLD);
    end
  end

  assign longest_stall = |cpu_stall;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      req_c[i]    = 1'b0;
      capture[i]  = 1'b0;
      rdata_ld[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (cpu_en[i]) begin
            capture[i] = 1'b1;
            state_d[i] = REQ;
          end
        end
        REQ: begin
          req_c[i] = 1'b1;
          if (bus.addr_ok[i]) begin
            rdata_ld[i] = bus.data_ok[i];
            state_d[i]  = bus.data_ok[i] ? HOLD : WAIT;
          end
        end
        WAIT: begin
          if (bus.data_ok[i]) begin
            rdata_ld[i] = 1'b1;
            state_d[i]  = HOLD;
          end
        end
        HOLD: begin
          // All held channels release together on the cycle the pipeline advances.
          if (!longest_stall) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= IDLE;
      wr_q    <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        if (capture[i]) begin
          wr_q[i]              <= |cpu_wen[4*i +: 4];
          size_q[2*i +: 2]     <= wen_to_size(cpu_wen[4*i +: 4]);
          addr_q[AW*i +: AW]   <= cpu_addr[AW*i +: AW];
          wdata_q[32*i +: 32]  <= cpu_wdata[32*i +: 32];
        end
        if (rdata_ld[i]) rdata_q[32*i +: 32] <= bus.rdata[32*i +: 32];
      end
    end
  end

  assign bus.req   = req_c;
  assign bus.wr    = wr_q;
  assign bus.size  = size_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign cpu_rdata = rdata_q;

`ifdef SRAM_BRIDGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
      perf_req_cnt   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cpu_stall[i])
          perf_stall_cnt[32*i +: 32] <= perf_stall_cnt[32*i +: 32] + 32'd1;
        if (req_c[i] && bus.addr_ok[i])
          perf_req_cnt[32*i +: 32] <= perf_req_cnt[32*i +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_multi_bridge.sv
// Self-checking bench for sram_like_multi_bridge: directed cycle-exact stimulus with a
// read-data scoreboard popped whenever a channel's stall drops while it is enabled.
module tb_sram_like_multi_bridge;
  localparam int NCH = 2;
  localparam int AW  = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    cpu_en;
  logic [4*NCH-1:0]  cpu_wen;
  logic [AW*NCH-1:0] cpu_addr;
  logic [32*NCH-1:0] cpu_wdata;
  logic [32*NCH-1:0] cpu_rdata;
  logic [NCH-1:0]    cpu_stall;
  logic              longest_stall;
`ifdef SRAM_BRIDGE_PERF_EN
  logic [32*NCH-1:0] perf_stall_cnt;
  logic [32*NCH-1:0] perf_req_cnt;
`endif

  sram_like_multi_bridge_if #(.NCH(NCH), .AW(AW)) bus ();

  sram_like_multi_bridge #(.NCH(NCH), .AW(AW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_en        (cpu_en),
    .cpu_wen       (cpu_wen),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .longest_stall (longest_stall),
    .bus           (bus)
`ifdef SRAM_BRIDGE_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_req_cnt  (perf_req_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [NCH-1:0] prev_stall = '0;
  int req_cyc[NCH];
  int hs_cnt[NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [3:0] wen, input logic [31:0] a,
                        input logic [31:0] wd);
    cpu_wen[4*ch +: 4]    = wen;
    cpu_addr[AW*ch +: AW] = a;
    cpu_wdata[32*ch +: 32] = wd;
  endtask

  task automatic push_exp(input int ch, input logic [31:0] v);
    if (ch == 0) exp_q0.push_back(v);
    else         exp_q1.push_back(v);
  endtask

  // Scoreboard and bus-activity monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (resetn && cpu_en[i] && !cpu_stall[i] && prev_stall[i]) begin
        if (i == 0) begin
          if (exp_q0.size() > 0) check("sb_rdata0", cpu_rdata[31:0], exp_q0.pop_front());
          else check("sb_underflow0", 64'(exp_q0.size()), 64'd1);
        end else begin
          if (exp_q1.size() > 0) check("sb_rdata1", cpu_rdata[63:32], exp_q1.pop_front());
          else check("sb_underflow1", 64'(exp_q1.size()), 64'd1);
        end
      end
      if (resetn && bus.req[i]) req_cyc[i]++;
      if (resetn && bus.req[i] && bus.addr_ok[i]) hs_cnt[i]++;
    end
    prev_stall = cpu_stall & {NCH{resetn}};
  end

  // One complete transaction with addr_ok and data_ok in the first REQ cycle.
  task automatic single(input int ch, input logic [3:0] wen, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input logic [1:0] exp_size);
    cpu_en[ch] = 1'b1;
    set_ch(ch, wen, a, wd);
    #1;
    check($sformatf("c0_stall%0d", ch), cpu_stall[ch], 1'b1);
    check("c0_longest", longest_stall, 1'b1);
    tick();
    check($sformatf("c1_req%0d", ch), bus.req[ch], 1'b1);
    check($sformatf("c1_wr%0d", ch), bus.wr[ch], |wen);
    check($sformatf("c1_size%0d", ch), bus.size[2*ch +: 2], exp_size);
    check($sformatf("c1_addr%0d", ch), bus.addr[AW*ch +: AW], a);
    check($sformatf("c1_wdata%0d", ch), bus.wdata[32*ch +: 32], wd);
    bus.addr_ok[ch] = 1'b1;
    bus.data_ok[ch] = 1'b1;
    bus.rdata[32*ch +: 32] = rd;
    push_exp(ch, rd);
    tick();
    bus.addr_ok[ch] = 1'b0;
    bus.data_ok[ch] = 1'b0;
    #1;
    check($sformatf("c2_req%0d", ch), bus.req[ch], 1'b0);
    check("c2_longest", longest_stall, 1'b0);
    check($sformatf("c2_rdata%0d", ch), cpu_rdata[32*ch +: 32], rd);
    tick();
    cpu_en[ch] = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    int b_req[NCH];
    int b_hs[NCH];
    resetn      = 1'b0;
    cpu_en      = '0;
    cpu_wen     = '0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    bus.addr_ok = '0;
    bus.data_ok = '0;
    bus.rdata   = '0;
    for (int i = 0; i < NCH; i++) begin
      req_cyc[i] = 0;
      hs_cnt[i]  = 0;
    end
    tick();
    tick();
    check("rst_req", bus.req, 2'b00);
    check("rst_wr", bus.wr, 2'b00);
    check("rst_size", bus.size, 4'h0);
    check("rst_addr", bus.addr, 64'h0);
    check("rst_wdata", bus.wdata, 64'h0);
    check("rst_rdata", cpu_rdata, 64'h0);
    check("rst_stall", cpu_stall, 2'b00);
    check("rst_longest", longest_stall, 1'b0);
    resetn = 1'b1;
    tick();

    // Single read on the instruction channel, then sized stores and an odd pattern.
    single(0, 4'b0000, 32'hBFC0_0000, 32'h0, 32'h3C1D_0001, 2'd2);
    single(1, 4'b0001, 32'h0000_0103, 32'h0000_00AA, 32'h1111_1111, 2'd0);
    single(1, 4'b1100, 32'h0000_0202, 32'hBEEF_0000, 32'h2222_2222, 2'd1);
    single(0, 4'b0010, 32'h0000_0011, 32'h0000_5A00, 32'h3333_3333, 2'd0);
    single(1, 4'b0101, 32'h0000_0400, 32'h0505_0505, 32'h4444_4444, 2'd2);

    // Skewed completion: ch0 finishes at cycle 2, ch1 at cycle 6.
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      b_req[i] = req_cyc[i];
      b_hs[i]  = hs_cnt[i];
    end
    cpu_en = 2'b11;
    set_ch(0, 4'b0000, 32'h0000_1000, 32'h0);
    set_ch(1, 4'b0000, 32'h0000_2000, 32'h0);
    #1;
    check("sk_c0_stall", cpu_stall, 2'b11);
    tick();
    check("sk_c1_req", bus.req, 2'b11);
    bus.addr_ok = 2'b11;
    tick();
    bus.addr_ok = 2'b00;
    bus.data_ok = 2'b01;
    bus.rdata[31:0] = 32'hA0A0_0001;
    push_exp(0, 32'hA0A0_0001);
    #1;
    check("sk_c2_stall", cpu_stall, 2'b11);
    tick();
    bus.data_ok = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sk_hold_stall0", cpu_stall[0], 1'b0);
      check("sk_hold_rdata0", cpu_rdata[31:0], 32'hA0A0_0001);
      check("sk_hold_longest", longest_stall, 1'b1);
      check("sk_hold_req", bus.req, 2'b00);
      tick();
    end
    bus.data_ok = 2'b10;
    bus.rdata[63:32] = 32'hB0B0_0002;
    push_exp(1, 32'hB0B0_0002);
    #1;
    check("sk_c6_longest", longest_stall, 1'b1);
    tick();
    bus.data_ok = 2'b00;
    #1;
    check("sk_c7_longest", longest_stall, 1'b0);
    check("sk_c7_rdata0", cpu_rdata[31:0], 32'hA0A0_0001);
    check("sk_c7_rdata1", cpu_rdata[63:32], 32'hB0B0_0002);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("sk_req_cycles%0d", i), 64'(req_cyc[i] - b_req[i]), 64'd1);
      check($sformatf("sk_handshakes%0d", i), 64'(hs_cnt[i] - b_hs[i]), 64'd1);
    end
`ifdef SRAM_BRIDGE_PERF_EN
    check("perf_stall0", perf_stall_cnt[31:0], 32'd3);
    check("perf_stall1", perf_stall_cnt[63:32], 32'd7);
    check("perf_req0", perf_req_cnt[31:0], 32'd1);
    check("perf_req1", perf_req_cnt[63:32], 32'd1);
`endif
    tick();
    // Both channels back in IDLE: a still-high enable stalls again and reissues next cycle.
    #1;
    check("sk_c8_idle_stall", cpu_stall, 2'b11);
    set_ch(0, 4'b0000, 32'h0000_1004, 32'h0);
    set_ch(1, 4'b1111, 32'h0000_2004, 32'h7777_8888);
    tick();
    check("b2b_req", bus.req, 2'b11);
    check("b2b_addr0", bus.addr[31:0], 32'h0000_1004);
    check("b2b_wr", bus.wr, 2'b10);
    bus.addr_ok = 2'b11;
    bus.data_ok = 2'b11;
    bus.rdata   = {32'hD0D0_0004, 32'hC0C0_0003};
    push_exp(0, 32'hC0C0_0003);
    push_exp(1, 32'hD0D0_0004);
    tick();
    bus.addr_ok = 2'b00;
    bus.data_ok = 2'b00;
    #1;
    check("b2b_stall", cpu_stall, 2'b00);
    check("b2b_rdata", cpu_rdata, {32'hD0D0_0004, 32'hC0C0_0003});
    tick();
    cpu_en = 2'b00;
    tick();

    // Delayed addr_ok on ch1: request fields must stay registered while the core side moves.
    cpu_en = 2'b10;
    set_ch(1, 4'b1111, 32'h8000_1234, 32'hDEAD_BEEF);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_ch(1, 4'b0001, 32'(k), 32'(k + 100));
      #1;
      check("dl_req", bus.req, 2'b10);
      check("dl_addr", bus.addr[63:32], 32'h8000_1234);
      check("dl_size", bus.size[3:2], 2'd2);
      check("dl_wdata", bus.wdata[63:32], 32'hDEAD_BEEF);
      tick();
    end
    bus.addr_ok = 2'b10;
    #1;
    check("dl_req_acc", bus.req, 2'b10);
    tick();
    bus.addr_ok = 2'b00;
    #1;
    check("dl_wait_req", bus.req, 2'b00);
    check("dl_wait_stall", cpu_stall[1], 1'b1);
    tick();
    tick();
    bus.data_ok = 2'b10;
    bus.rdata[63:32] = 32'hCAFE_F00D;
    push_exp(1, 32'hCAFE_F00D);
    #1;
    check("dl_c9_stall", cpu_stall[1], 1'b1);
    tick();
    bus.data_ok = 2'b00;
    #1;
    check("dl_hold_stall", cpu_stall, 2'b00);
    check("dl_hold_rdata", cpu_rdata[63:32], 32'hCAFE_F00D);
    tick();
    cpu_en = 2'b00;

    // Reset while ch1 waits for data; the late data_ok must be ignored.
    cpu_en = 2'b10;
    set_ch(1, 4'b0000, 32'h0000_3000, 32'h0);
    tick();
    bus.addr_ok = 2'b10;
    tick();
    bus.addr_ok = 2'b00;
    cpu_en      = 2'b00;
    resetn      = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    check("rm_stall", cpu_stall, 2'b00);
    check("rm_req", bus.req, 2'b00);
    tick();
    tick();
    bus.data_ok = 2'b10;
    bus.rdata[63:32] = 32'h5555_5555;
    tick();
    bus.data_ok = 2'b00;
    #1;
    check("rm_rdata", cpu_rdata, 64'h0);
    check("rm_stall_after", cpu_stall, 2'b00);
    check("rm_longest", longest_stall, 1'b0);
    check("rm_req_after", bus.req, 2'b00);
    check("rm_addr", bus.addr, 64'h0);
    tick();

    check("sb_left0", 64'(exp_q0.size()), 64'd0);
    check("sb_left1", 64'(exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_like_multi_bridge.md
Name: sram_like_multi_bridge

Overview:
- Parametrised bridge between the core's enable/stall memory ports (instruction fetch, data access, extra channels) and NCH independent sram-like master channels (req/addr_ok/data_ok).
- Per-channel request FSM with registered address and write data, and rdata capture.
- Generates per-channel stalls and a global longest_stall.
- A channel whose data returns early holds its result until every channel is done, so the pipeline advances once with all data valid and no access is reissued.

Parameters:
- NCH, 2, number of channels (ch0 = inst, ch1 = data, further channels optional)
- AW, 32, address width; data width is fixed at 32, byte-enable width 4

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- cpu_en  in  NCH  per-channel access enable from core
- cpu_wen  in  4*NCH  byte write enables; all zero means read
- cpu_addr  in  AW*NCH  byte address
- cpu_wdata  in  32*NCH  store data
- cpu_rdata  out  32*NCH  returned data, valid in HOLD
- cpu_stall  out  NCH  per-channel stall
- longest_stall  out  1  OR of cpu_stall, drives the pipeline-wide stall
- req  out  NCH  sram-like request
- wr  out  NCH  1 = write
- size  out  2*NCH  0 = byte, 1 = half, 2 = word
- addr  out  AW*NCH  request address
- wdata  out  32*NCH  request write data
- addr_ok  in  NCH  address accepted
- data_ok  in  NCH  data phase complete
- rdata  in  32*NCH  read data

Behaviour:
- Reset (resetn=0 at a clk edge): all channels go to IDLE. req, wr, size, addr, wdata, cpu_rdata are 0; cpu_stall and longest_stall are 0. Reset mid-transaction abandons it; a data_ok arriving later is ignored because the channel is in IDLE.
- Per-channel FSM:
  - IDLE: if cpu_en=1, register addr/wdata/wr/size and go to REQ.
  - REQ: req=1, outputs held stable. On addr_ok&data_ok, latch rdata and go to HOLD. On addr_ok only, go to WAIT.
  - WAIT: req=0. On data_ok, latch rdata into cpu_rdata and go to HOLD.
  - HOLD: cpu_rdata stable. When longest_stall=0 go to IDLE. Otherwise stay in HOLD, issue no new request and ignore cpu_en.
- cpu_stall[i] = cpu_en[i] & (state != HOLD). This covers IDLE with en=1, which is combinational, so the stall is raised in the same cycle as the enable.
- longest_stall = |cpu_stall.
- Minimum latency with addr_ok and data_ok both in the first REQ cycle: en at cycle 0, req at cycle 1, HOLD at cycle 2, stall low from cycle 2.
- Request encoding:
  - wr = |wen.
  - size: 1111 → 2; 0011 or 1100 → 1; one-hot → 0; wen=0 → 2.
  - Any other wen pattern is illegal; map to 2.
  - addr is passed unaligned as given.
- Release: HOLD→IDLE occurs in the same cycle for all held channels, the cycle the pipeline advances. A channel whose en is 0 contributes no stall.
- Back-to-back: after HOLD→IDLE, a new en issues next cycle. Exactly one sram-like transaction per pipeline advance per channel.
- Channels are fully independent except for the shared HOLD release.

Optional Feature:
- Macro: SRAM_BRIDGE_PERF_EN.
- Defined:
  - adds output perf_stall_cnt (32*NCH); per channel, a 32-bit counter increments each cycle cpu_stall[i]=1, wrapping at 2^32.
  - adds output perf_req_cnt (32*NCH), counting accepted addr_ok handshakes.
  - both clear on reset.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single read, ch0: en=1, addr=0xBFC00000, wen=0; addr_ok and data_ok in the first REQ cycle, rdata=0x3C1D0001 → req high 1 cycle, size=2, wr=0; cpu_rdata=0x3C1D0001 at cycle 2; longest_stall high for cycles 0-1 only.
- Skewed completion: ch0 and ch1 both en; ch0 data_ok at cycle 2, ch1 data_ok at cycle 6 → ch0 HOLD from cycle 3 with stable data and cpu_stall[0]=0; longest_stall low from cycle 7; both IDLE at cycle 8; exactly one req per channel.
- Store sizes, ch1: wen=0001, addr=0x...3 → wr=1, size=0; wen=1100 → size=1; wen=1111, wdata=0xDEADBEEF → size=2, wdata=0xDEADBEEF held until addr_ok.
- Delayed addr_ok: addr_ok withheld 5 cycles → req, addr, size held constant all 5 cycles; then WAIT; data_ok 3 cycles later → HOLD.
- Reset mid-op: resetn=0 while ch1 in WAIT; data_ok pulse 2 cycles after release → channel stays IDLE, cpu_rdata=0, no stall.
- PERF (macro defined): the skewed-completion scenario → perf_stall_cnt[0]=3, perf_stall_cnt[1]=7, perf_req_cnt=1 each.
